// File: rtl/id_hazard_scheduler.sv
// id_hazard_scheduler: decode-stage stall/bubble scheduler tracking in-flight register writers
module id_hazard_scheduler #(
    parameter bit FORWARD   = 1'b0,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             bubble_id_ex,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       load;
    } slot_t;

    slot_t e, m, w;
    logic  hit_e, hit_m, hit_w, hazard, stall, issue;

    function automatic logic src_hit(input slot_t s, input logic [4:0] a, input logic [4:0] b);
        return s.valid & (((a != 5'd0) & (s.rd == a)) | ((b != 5'd0) & (s.rd == b)));
    endfunction

    function automatic logic [31:0] onehot(input slot_t s);
        return s.valid ? (32'd1 << s.rd) : 32'd0;
    endfunction

    // operand availability check against the shadow slots; flush overrides any stall
    always_comb begin
        hit_e        = src_hit(e, id_rs1_addr, id_rs2_addr);
        hit_m        = src_hit(m, id_rs1_addr, id_rs2_addr);
        hit_w        = src_hit(w, id_rs1_addr, id_rs2_addr);
        hazard       = id_valid & (FORWARD ? (e.load & hit_e) : (hit_e | hit_m | (hit_w & !WB_BYPASS)));
        stall        = hazard & !flush;
        issue        = id_valid & !hazard & !flush & id_reg_write & (id_rd_addr != 5'd0);
        stall_pc     = stall;
        stall_if_id  = stall;
        bubble_id_ex = stall | flush;
        pending_mask = (onehot(e) | onehot(m) | onehot(w)) & ~32'd1;
    end

    // shift producers through EX/MEM/WB every cycle and count stall cycles with saturation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e         <= '0;
            m         <= '0;
            w         <= '0;
            stall_cnt <= '0;
        end else begin
            w <= m;
            m <= e;
            e <= issue ? {1'b1, id_rd_addr, id_mem_read} : '0;
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_hazard_scheduler.sv
// tb_id_hazard_scheduler: directed checks of the decode hazard scheduler in three configurations
module tb_id_hazard_scheduler;
    logic        clk, reset, v, rw, mr, fl;
    logic [4:0]  r1, r2, rd;
    logic        st0, si0, bb0, st1, si1, bb1, st2, si2, bb2;
    logic [31:0] pm0, pm1, pm2, sc0, sc1;
    logic [3:0]  sc2;
    int          total = 0;
    int          pass  = 0;

    typedef struct {
        logic        v;
        logic [4:0]  r1, r2, rd;
        logic        rw, mr, fl;
        logic        st, bb;
        logic [31:0] pm, sc;
    } vec_t;

    vec_t tbl[14];

    id_hazard_scheduler #(.FORWARD(1'b0), .WB_BYPASS(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .id_valid(v), .id_rs1_addr(r1), .id_rs2_addr(r2),
        .id_rd_addr(rd), .id_reg_write(rw), .id_mem_read(mr), .flush(fl),
        .stall_pc(st0), .stall_if_id(si0), .bubble_id_ex(bb0), .pending_mask(pm0), .stall_cnt(sc0));

    id_hazard_scheduler #(.FORWARD(1'b0), .WB_BYPASS(1'b0), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .id_valid(v), .id_rs1_addr(r1), .id_rs2_addr(r2),
        .id_rd_addr(rd), .id_reg_write(rw), .id_mem_read(mr), .flush(fl),
        .stall_pc(st1), .stall_if_id(si1), .bubble_id_ex(bb1), .pending_mask(pm1), .stall_cnt(sc1));

    id_hazard_scheduler #(.FORWARD(1'b1), .WB_BYPASS(1'b1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .id_valid(v), .id_rs1_addr(r1), .id_rs2_addr(r2),
        .id_rd_addr(rd), .id_reg_write(rw), .id_mem_read(mr), .flush(fl),
        .stall_pc(st2), .stall_if_id(si2), .bubble_id_ex(bb2), .pending_mask(pm2), .stall_cnt(sc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic iv, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic iw, input logic im, input logic f);
        v = iv; r1 = a; r2 = b; rd = d; rw = iw; mr = im; fl = f;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd0};
        tbl[1]  = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2,  32'd0};
        tbl[2]  = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2,  32'd1};
        tbl[3]  = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,  32'd2};
        tbl[4]  = '{1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8,  32'd2};
        tbl[5]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8,  32'd2};
        tbl[6]  = '{1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8,  32'd2};
        tbl[7]  = '{1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,  32'd2};
        tbl[8]  = '{1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2,  32'd2};
        tbl[9]  = '{1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2,  32'd3};
        tbl[10] = '{1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'd3};
        tbl[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'd3};
        tbl[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'd3};
        tbl[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'd3};

        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        chk("reset stall_pc", {31'd0, st0}, 32'd0);
        chk("reset bubble", {31'd0, bb0}, 32'd0);
        chk("reset pending_mask", pm0, 32'd0);
        chk("reset stall_cnt", sc0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d stall_pc", i), {31'd0, st0}, {31'd0, tbl[i].st});
            chk($sformatf("vec%0d stall_if_id", i), {31'd0, si0}, {31'd0, tbl[i].st});
            chk($sformatf("vec%0d bubble", i), {31'd0, bb0}, {31'd0, tbl[i].bb});
            chk($sformatf("vec%0d pending_mask", i), pm0, tbl[i].pm);
            chk($sformatf("vec%0d stall_cnt", i), sc0, tbl[i].sc);
            step();
        end
        chk("table final stall_cnt", sc0, 32'd3);

        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
        step();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("nobyp c%0d stall", c), {31'd0, st1}, {31'd0, c < 4});
            chk($sformatf("nobyp c%0d mask", c), pm1, (c < 4) ? 32'h2 : 32'h0);
            chk($sformatf("byp c%0d stall", c), {31'd0, st0}, {31'd0, c < 3});
            chk($sformatf("fwd c%0d stall", c), {31'd0, st2}, 32'd0);
            step();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("byp stall_cnt", sc0, 32'd2);
        chk("nobyp stall_cnt", sc1, 32'd3);
        chk("fwd no-load stall_cnt", {28'd0, sc2}, 32'd0);

        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("load-use stall", {31'd0, st2}, 32'd1);
        chk("load-use bubble", {31'd0, bb2}, 32'd1);
        step();
        chk("load-use release", {31'd0, st2}, 32'd0);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu-use no stall", {31'd0, st2}, 32'd0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fwd stall_cnt", {28'd0, sc2}, 32'd1);

        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("pre-reset stall", {31'd0, st2}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset stall", {31'd0, st2}, 32'd0);
        chk("async reset bubble", {31'd0, bb2}, 32'd0);
        chk("async reset mask", pm2, 32'd0);
        chk("async reset cnt", {28'd0, sc2}, 32'd0);
        chk("async reset stall nofwd", {31'd0, st0}, 32'd0);
        chk("async reset mask nofwd", pm0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post-reset no stall", {31'd0, st0}, 32'd0);
        chk("post-reset no stall fwd", {31'd0, st2}, 32'd0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post-reset issued", pm0, 32'h40);

        do_reset();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        repeat (40) step();
        chk("cnt saturation", {28'd0, sc2}, 32'd15);
        step();
        step();
        chk("cnt held at max", {28'd0, sc2}, 32'd15);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/id_hazard_scheduler.md
Name: id_hazard_scheduler

Overview:
- Stall/bubble scheduler for the decode stage. Issues one instruction per cycle into EX.
- Tracks in-flight register writers in a 3-slot shadow pipeline (EX, MEM, WB).
- Compares the decoding instruction's source registers against those slots. Holds PC and IF/ID, and injects an ID/EX bubble, when an operand is unavailable.
- Sits beside the ID stage and drives its hazard interface signals.

Parameters:
- FORWARD, 0, 1 = EX/MEM forwarding exists; only load-use stalls. 0 = no forwarding; any pending producer stalls.
- WB_BYPASS, 1, 1 = register file is write-first, so a match in the WB slot does not stall.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1_addr  in  5  source 1 name from decode
- id_rs2_addr  in  5  source 2 name from decode; already 0 when ALUSrcB selects the immediate
- id_rd_addr  in  5  destination name
- id_reg_write  in  1  decoded instruction writes rd
- id_mem_read  in  1  decoded instruction is a load
- flush  in  1  taken branch/jump resolved in EX; the instruction in IF/ID is wrong-path
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- bubble_id_ex  out  1  load NOP into ID/EX
- pending_mask  out  32  bit r = 1 when any valid slot holds rd = r; bit 0 always 0
- stall_cnt  out  CNT_W  cycles in which a hazard stall was asserted

Behaviour:
- Slot state: E, M, W, each holding {valid, rd[4:0], load}.
  - W is the instruction writing the register file this cycle.
  - M is the instruction in MEM.
  - E is the instruction in EX.
- Match rule: match(s, rs) = s.valid & (rs != 0) & (s.rd == rs). Register x0 never creates a hazard.
- Source match: src_hit(s) = match(s, id_rs1_addr) | match(s, id_rs2_addr).
- Hazard when FORWARD=0: hazard = id_valid & (src_hit(E) | src_hit(M) | (src_hit(W) & !WB_BYPASS)).
- Hazard when FORWARD=1: hazard = id_valid & E.load & src_hit(E).
- Stall gating: stall = hazard & !flush.
  - flush has priority; a wrong-path instruction never stalls.
- Outputs (combinational, same cycle):
  - stall_pc = stall_if_id = stall.
  - bubble_id_ex = stall | flush.
- Issue: issue = id_valid & !hazard & !flush & id_reg_write & (id_rd_addr != 0).
- Slot update on every rising edge (slots shift unconditionally; no back-pressure input):
  - W <= M
  - M <= E
  - E <= issue ? {1, id_rd_addr, id_mem_read} : {0, 0, 0}
- Dependency retirement: a stalled consumer re-evaluates each cycle as producers shift out. With FORWARD=0 and WB_BYPASS=1, a back-to-back dependency stalls exactly 2 cycles.
- pending_mask: combinational OR of the one-hot decodes of the valid E, M and W slots.
- stall_cnt:
  - increments by 1 on each rising edge where stall = 1;
  - saturates at 2^CNT_W - 1;
  - does not count flush cycles.
- Reset (reset = 0, asynchronous assert): all slots invalid, rd = 0, load = 0; stall_cnt = 0.
  - All outputs are therefore 0: stall_pc, stall_if_id, bubble_id_ex, pending_mask.
  - Deassertion is sampled at the next rising edge.
  - Reset during a stall drops all tracked producers; the next instruction issues without stall.
- Boundary cases:
  - id_valid = 0: no stall, no issue; E loads invalid.
  - rs1 == rs2 matching: single stall, same as one match.
  - A producer in E and in M with the same rd: both tracked, independently retired.
  - An instruction with rd = 0 or reg_write = 0: never recorded.

Test Plan:
- FORWARD=0, WB_BYPASS=1: addi x1 at cycle 0, then add x3,x1,x2 in ID at cycle 1 -> stall high on cycles 1-2, low on cycle 3; then the add issues; stall_cnt = 2.
- FORWARD=0, WB_BYPASS=0, same sequence -> 3 stall cycles; pending_mask = 0x2 during cycles 1-3 (the addi alone is tracked while the add is stalled).
- FORWARD=1: lw x5, then add x6,x5,x0 -> exactly 1 stall cycle.
  - Same sequence with add x6 producer instead of a load -> 0 stalls.
- addi x0,x0,1 followed by add x1,x0,x0 -> no stall; pending_mask stays 0.
- Hazard present and flush = 1 in the same cycle -> stall_pc = 0, bubble_id_ex = 1, E invalid next cycle; stall_cnt unchanged.
- reset pulled low for 1 cycle mid-stall -> all outputs 0 immediately. After release, a dependent instruction issues with no stall.
  - CNT_W=4 with a long load-use chain -> stall_cnt saturates at 15.
